// File: rtl/ula_controle.sv
`default_nettype none
// ============================================================================
// Module      : ula_controle
// Description : Multi-cycle driver/decoder for a registered ULA. Accepts an
//               ALUOp/funct request and two operands over valid/ready,
//               decodes the 4-bit ULA op code, drives the ULA for one
//               registered cycle, captures result + zero/erro/ovf flags and
//               presents them over a second valid/ready handshake.
//               Optional feature macro: ULA_CTRL_OVF_EN (signed overflow flag;
//               when undefined ovf is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module ula_controle (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:1]  aluop,
    input  logic [0:5]  funct,
    input  logic [0:31] op_a,
    input  logic [0:31] op_b,
    output logic [0:3]  inputULA,
    output logic [0:31] a,
    output logic [0:31] b,
    input  logic [0:31] outputULA,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] resultado,
    output logic        zero,
    output logic        erro,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [0:3] c_op_and = 4'b0000;
    localparam logic [0:3] c_op_or  = 4'b0001;
    localparam logic [0:3] c_op_add = 4'b0010;
    localparam logic [0:3] c_op_sub = 4'b0110;
    localparam logic [0:3] c_op_slt = 4'b0111;

    state_t       state_q, state_d;
    logic [0:3]   code_q, code_d;
    logic [0:31]  a_q, a_d;
    logic [0:31]  b_q, b_d;
    logic [0:31]  res_q, res_d;
    logic         zero_q, zero_d;
    logic         erro_q, erro_d;
    logic         ovf_q, ovf_d;
    logic         out_valid_q, out_valid_d;

    logic [0:3]   w_dec_code;
    logic         w_dec_err;
    logic         w_ovf;

    // Decode ALUOp/funct into the ULA op code, flagging unsupported combinations
    always_comb begin
        w_dec_code = c_op_and;
        w_dec_err  = 1'b0;
        case (aluop)
            2'b00: w_dec_code = c_op_add;
            2'b01: w_dec_code = c_op_sub;
            2'b10: begin
                case (funct)
                    6'b100000: w_dec_code = c_op_add;
                    6'b100010: w_dec_code = c_op_sub;
                    6'b100100: w_dec_code = c_op_and;
                    6'b100101: w_dec_code = c_op_or;
                    6'b101010: w_dec_code = c_op_slt;
                    default:   w_dec_err  = 1'b1;
                endcase
            end
            default: w_dec_err = 1'b1;
        endcase
    end

`ifdef ULA_CTRL_OVF_EN
    // Signed overflow from operand/result sign bits (bit 0 is the MSB)
    always_comb begin
        w_ovf = 1'b0;
        if (code_q == c_op_add) begin
            w_ovf = (a_q[0] == b_q[0]) && (outputULA[0] != a_q[0]);
        end else if (code_q == c_op_sub) begin
            w_ovf = (a_q[0] != b_q[0]) && (outputULA[0] != a_q[0]);
        end
    end
`else
    assign w_ovf = 1'b0;
`endif

    // Next-state and next-output computation; everything not touched holds
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        zero_d      = zero_q;
        erro_d      = erro_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_dec_err) begin
                        // No ULA cycle: the ULA-facing registers keep their last values
                        res_d       = '0;
                        zero_d      = 1'b0;
                        erro_d      = 1'b1;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        a_d     = op_a;
                        b_d     = op_b;
                        code_d  = w_dec_code;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                // outputULA now holds the result registered at the previous edge
                res_d       = outputULA;
                zero_d      = (outputULA == '0);
                erro_d      = 1'b0;
                ovf_d       = w_ovf;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            erro_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            erro_q      <= erro_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign inputULA  = code_q;
    assign a         = a_q;
    assign b         = b_q;
    assign resultado = res_q;
    assign zero      = zero_q;
    assign erro      = erro_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ula_controle.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_controle
// Description : Self-checking bench for ula_controle with a registered ULA
//               model and an operation-level reference model.
//               Honours ULA_CTRL_OVF_EN for the expected ovf flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_controle;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  ula_code;
    logic [31:0] ula_a;
    logic [31:0] ula_b;
    logic [31:0] ula_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        zero;
    logic        erro;
    logic        ovf;

    int          total;
    int          bad;
    logic [3:0]  last_code;

    ula_controle dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct     (funct),
        .op_a      (op_a),
        .op_b      (op_b),
        .inputULA  (ula_code),
        .a         (ula_a),
        .b         (ula_b),
        .outputULA (ula_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (res),
        .zero      (zero),
        .erro      (erro),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ULA with no reset
    always @(posedge clk) begin
        case (ula_code)
            4'b0000: ula_out <= ula_a & ula_b;
            4'b0001: ula_out <= ula_a | ula_b;
            4'b0010: ula_out <= ula_a + ula_b;
            4'b0110: ula_out <= ula_a - ula_b;
            4'b0111: ula_out <= (ula_a < ula_b) ? 32'd1 : 32'd0;
            default: ula_out <= 32'hDEAD_BEEF;
        endcase
    end

    // Operation-level reference: what the instruction means, not how it is decoded
    task automatic model(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] x, input logic [31:0] y,
                         output logic err, output logic [31:0] r,
                         output logic z, output logic ov, output logic [3:0] code);
        string  kind;
        longint s;
        longint lim;
        kind = "err";
        if (op == 2'd0) kind = "add";
        else if (op == 2'd1) kind = "sub";
        else if (op == 2'd2) begin
            if (fn == 6'd32) kind = "add";
            else if (fn == 6'd34) kind = "sub";
            else if (fn == 6'd36) kind = "and";
            else if (fn == 6'd37) kind = "or";
            else if (fn == 6'd42) kind = "slt";
        end
        lim  = 64'sh7FFF_FFFF;
        s    = 0;
        err  = 1'b0;
        r    = 32'd0;
        code = last_code;
        if (kind == "add") begin
            r = x + y; code = 4'b0010;
            s = longint'($signed(x)) + longint'($signed(y));
        end else if (kind == "sub") begin
            r = x - y; code = 4'b0110;
            s = longint'($signed(x)) - longint'($signed(y));
        end else if (kind == "and") begin
            r = x & y; code = 4'b0000;
        end else if (kind == "or") begin
            r = x | y; code = 4'b0001;
        end else if (kind == "slt") begin
            r = (x < y) ? 32'd1 : 32'd0; code = 4'b0111;
        end else begin
            err = 1'b1;
        end
        z = !err && (r == 32'd0);
`ifdef ULA_CTRL_OVF_EN
        ov = (s > lim) || (s < -lim - 1);
`else
        ov = 1'b0;
`endif
    endtask

    // Present one request, return accept-to-valid latency and ULA drive seen in EXEC
    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic [3:0] exec_code,
                          output logic [31:0] exec_a, output logic [31:0] exec_b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1; aluop = op; funct = fn; op_a = x; op_b = y;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        op_a      = $urandom; op_b = $urandom;
        exec_code = ula_code;
        exec_a    = ula_a;
        exec_b    = ula_b;
        lat       = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Complete the output handshake
    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, zero, erro, ovf, ula_code, ula_a, ula_b, res} !== '0) begin
            bad++;
            $display("FAIL reset_state: ov=%0b z=%0b e=%0b f=%0b code=%h a=%h b=%h r=%h required all 0",
                     out_valid, zero, erro, ovf, ula_code, ula_a, ula_b, res);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
        last_code = 4'b0000;
    endtask

    // Check one completed transaction against the model, then finish it
    task automatic test_one(input string name, input logic [1:0] op, input logic [5:0] fn,
                            input logic [31:0] x, input logic [31:0] y);
        int          lat;
        logic [3:0]  ec;
        logic [31:0] ea, eb;
        logic        m_err, m_z, m_ov;
        logic [31:0] m_r;
        logic [3:0]  m_code;
        model(op, fn, x, y, m_err, m_r, m_z, m_ov, m_code);
        run_op(op, fn, x, y, lat, ec, ea, eb);
        total++;
        if (lat != (m_err ? 0 : 2)) begin
            bad++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, m_err ? 0 : 2);
        end
        total++;
        if (ec !== m_code || (!m_err && (ea !== x || eb !== y))) begin
            bad++;
            $display("FAIL %s_ula_drive: code=%h a=%h b=%h required code=%h a=%h b=%h",
                     name, ec, ea, eb, m_code, x, y);
        end
        total++;
        if ({res, zero, erro, ovf} !== {m_r, m_z, m_err, m_ov}) begin
            bad++;
            $display("FAIL %s_result: r=%h z=%b e=%b v=%b required r=%h z=%b e=%b v=%b",
                     name, res, zero, erro, ovf, m_r, m_z, m_err, m_ov);
        end
        last_code = m_code;
        finish_op();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_handshake: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        test_one("add_5_7",   2'b00, 6'd0,  32'd5,        32'd7);
        total++;
        if (res !== 32'd12) begin
            bad++;
            $display("FAIL add_5_7_value: got %h required 0000000c", res);
        end
        test_one("sub_zero",  2'b01, 6'd0,  32'h1234,     32'h1234);
        test_one("slt_unsig", 2'b10, 6'd42, 32'd3,        32'hFFFF_FFFF);
        test_one("or",        2'b10, 6'd37, 32'hF000_000F, 32'h0000_F0F0);
        test_one("rsub",      2'b10, 6'd34, 32'd1,        32'd2);
        test_one("ovf_add",   2'b00, 6'd0,  32'h7FFF_FFFF, 32'd1);
        test_one("ovf_sub",   2'b01, 6'd0,  32'h8000_0000, 32'd1);
    endtask

    task automatic test_stall();
        int          lat;
        logic [3:0]  ec;
        logic [31:0] ea, eb;
        int          errs;
        run_op(2'b10, 6'd36, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat, ec, ea, eb);
        total++;
        if (res !== 32'h00F0_00F0 || lat != 2) begin
            bad++;
            $display("FAIL and_result: r=%h lat=%0d required 00f000f0 lat=2", res, lat);
        end
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; aluop = 2'b00; op_a = 32'd9; op_b = 32'd9;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== 32'h00F0_00F0 ||
                {zero, erro, ovf} !== 3'b000 || ula_code !== 4'b0000) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL stall_hold: %0d cycles disturbed required 0", errs);
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish_op();
        last_code = 4'b0000;
        errs = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || ula_code !== 4'b0000) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL stall_ignored_req: %0d cycles with activity required 0", errs);
        end
    endtask

    task automatic test_error();
        test_one("err_aluop11",  2'b11, 6'd32, 32'd1, 32'd2);
        test_one("err_funct0",   2'b10, 6'd0,  32'd3, 32'd4);
        total++;
        if (ula_code !== 4'b0000) begin
            bad++;
            $display("FAIL err_code_held: inputULA=%h required 0", ula_code);
        end
    endtask

    task automatic test_reset_capt();
        int errs;
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b00; op_a = 32'd100; op_b = 32'd23;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || ula_code !== 4'b0000 || ula_a !== 32'd0 || res !== 32'd0) begin
            bad++;
            $display("FAIL rst_capt_clear: ov=%b code=%h a=%h r=%h required 0", out_valid, ula_code, ula_a, res);
        end
        @(negedge clk);
        rst = 1'b0;
        last_code = 4'b0000;
        errs = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL rst_capt_abandon: %0d bad cycles required 0", errs);
        end
        test_one("add_2_2", 2'b00, 6'd0, 32'd2, 32'd2);
        total++;
        if (res !== 32'd4) begin
            bad++;
            $display("FAIL add_2_2_value: got %h required 00000004", res);
        end
    endtask

    task automatic test_random();
        logic [5:0]  fl [5];
        logic [31:0] el [5];
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] x, y;
        fl[0] = 6'd32; fl[1] = 6'd34; fl[2] = 6'd36; fl[3] = 6'd37; fl[4] = 6'd42;
        el[0] = 32'd0; el[1] = 32'd1; el[2] = 32'h7FFF_FFFF; el[3] = 32'h8000_0000; el[4] = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 3) != 0) ? fl[$urandom_range(0, 4)] : 6'($urandom);
            x  = ($urandom_range(0, 2) == 0) ? el[$urandom_range(0, 4)] : $urandom;
            y  = ($urandom_range(0, 2) == 0) ? el[$urandom_range(0, 4)] : $urandom;
            test_one("rand", op, fn, x, y);
        end
    endtask

    initial begin
        total = 0; bad = 0; last_code = 4'b0000;
        rst = 1'b1; in_valid = 1'b0; aluop = 2'b00; funct = 6'd0;
        op_a = 32'd0; op_b = 32'd0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_error();
        test_reset_capt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ula_controle.md
# ula_controle

Multi-cycle driver and decoder for the registered ULA. It accepts an instruction's ALUOp/funct fields and two operands through a valid/ready handshake, then decodes them into the 4-bit ULA operation code. It drives the ULA operand and code inputs, waits out the ULA's one-cycle registered latency, and captures the result together with zero, error and (optionally) overflow flags. The block sits between the control/decode stage and the ULA, and hands results to the write-back side through a second valid/ready handshake.

## Interface

- No parameters; all widths fixed, bit 0 is MSB (`[0:N]` ordering).

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  block can accept; equals 1 only in IDLE
- `aluop`  in  2  00 = add, 01 = sub, 10 = R-type (use funct), 11 = invalid
- `funct`  in  6  R-type function field
- `op_a`, `op_b`  in  32  operands
- `inputULA`  out  4  op code to ULA
- `a`, `b`  out  32  operands to ULA
- `outputULA`  in  32  registered ULA result
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `resultado`  out  32  captured result
- `zero`  out  1  resultado == 0 (only when erro = 0)
- `erro`  out  1  unsupported aluop/funct
- `ovf`  out  1  signed overflow (see Configuration)

## Operation

- Decode:
  - aluop 00 → 0010; aluop 01 → 0110.
  - aluop 10 with funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111.
  - Any other combination → error.
- FSM states:
  - **IDLE:** `in_ready` = 1. On `in_valid` at an edge, register op_a→a, op_b→b and the code→inputULA. Next state is EXEC, or DONE directly on an error (resultado = 0, erro = 1, zero = 0, ovf = 0).
  - **EXEC:** a, b and inputULA are held stable; the ULA samples them at this edge. Next state is CAPT.
  - **CAPT:** at this edge, capture outputULA→resultado, compute zero/ovf, and set out_valid = 1. Next state is DONE.
  - **DONE:** out_valid = 1 and all result outputs are held. On `out_ready` at an edge: out_valid = 0, go to IDLE.
- a, b and inputULA hold their last values outside EXEC. The ULA result is read only in CAPT.
- SLT is unsigned (ULA semantics): result is 1 or 0, zero-extended.
- Arithmetic wraps modulo 2^32; no carry output.

## Timing

- Reset (asynchronous, effective immediately):
  - State forced to IDLE.
  - inputULA = 0000; a, b, resultado = 0.
  - out_valid, zero, erro, ovf = 0.
  - in_ready = 1 once reset is released.
- Latency from the accept edge E0:
  - Valid op: EXEC during E0→E1, ULA registers at E1, capture at E2. out_valid is high from just after E2.
  - Error: out_valid is high just after E0, with no ULA cycle.
- Throughput: at most one op per 4 cycles (accept, EXEC, CAPT, ≥1 DONE cycle).
  - A new accept is possible at the earliest on the edge after the DONE handshake; in_ready is low in DONE, so there is no same-edge accept.
- `in_valid` outside IDLE is ignored; the request must be held by the producer until in_ready.
- `out_ready` outside DONE is ignored.
- out_valid never drops without a handshake; resultado, zero, erro and ovf are stable while out_valid = 1.
- Reset during EXEC/CAPT/DONE: the operation is abandoned and no out_valid follows. A stale outputULA (the ULA has no reset) is never captured.

## Configuration

- `ULA_CTRL_OVF_EN` defined: ovf is computed at CAPT.
  - For code 0010: ovf = (a[0] == b[0]) && (outputULA[0] != a[0]).
  - For code 0110: ovf = (a[0] != b[0]) && (outputULA[0] != a[0]).
  - For all other codes: ovf = 0.
  - ovf is informational only; resultado is still delivered.
- Not defined: ovf is tied to 0 and no overflow logic is synthesized. All other behaviour is identical.

## Test plan

- Reset, then aluop 00, op_a = 5, op_b = 7, out_ready = 1 → inputULA = 0010 during EXEC; out_valid after 2 edges; resultado = 12, zero = 0, erro = 0.
- aluop 01, op_a = op_b = 0x1234 → resultado = 0, zero = 1; then aluop 10 / funct 101010 with a = 3, b = 0xFFFFFFFF → resultado = 1 (unsigned).
- aluop 10, funct 100100 with 0xF0F0_F0F0 & 0x0FF0_0FF0 → 0x00F0_00F0. Hold out_ready = 0 for 5 cycles → outputs stable, in_ready = 0, and a new in_valid is ignored.
- aluop 11 (and aluop 10 / funct 000000) → out_valid one edge after accept, erro = 1, resultado = 0, and inputULA is not updated.
- With `ULA_CTRL_OVF_EN`: add 0x7FFFFFFF + 1 → resultado = 0x80000000, ovf = 1. Sub 0x80000000 − 1 → ovf = 1. Without the macro, the same cases give ovf = 0.
- Assert rst in CAPT → out_valid never rises; in_ready = 1 after release, and the next add 2 + 2 returns 4.
